writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Final stage of the Y86-64 five-stage pipeline, directly downstream of the memory stage. It latches the memory stage's outputs into the W pipeline register and commits valE and valM into the 15-entry architectural register file. It serves the decode stage's two combinational register reads and exports the W fields for forwarding. It also owns program status: sticky halt on the first exceptional status, plus a count of retired instructions.

## Interface
- NREGS, 15, architectural registers; IDs 0–14; ID 15 = RNONE (no register)
- SAOK, 3'd1, normal status; any other stat value is exceptional (HLT=2, ADR=3, INS=4)
- INOP, 4'd1, icode inserted by a bubble

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall_W  in  1  hold the W register
- bubble_W  in  1  load a bubble into the W register
- m_icode  in  4  icode from the memory stage
- m_stat  in  3  status from the memory stage
- m_valE  in  64  valE from the memory stage
- m_valM  in  64  valM from the memory stage
- m_dstE  in  4  dstE from the memory stage
- m_dstM  in  4  dstM from the memory stage
- d_srcA  in  4  read port A register ID, driven by decode
- d_srcB  in  4  read port B register ID, driven by decode
- d_rvalA  out  64  register[d_srcA]; 0 when d_srcA = 15
- d_rvalB  out  64  register[d_srcB]; 0 when d_srcB = 15
- W_icode  out  4  W register icode
- W_stat  out  3  W register status
- W_valE  out  64  W register valE, used for forwarding
- W_valM  out  64  W register valM, used for forwarding
- W_dstE  out  4  W register dstE, used for forwarding
- W_dstM  out  4  W register dstM, used for forwarding
- Stat  out  3  program status: W_stat when W is valid, otherwise SAOK
- halted  out  1  sticky; set when an exceptional status is held in W
- retired  out  64  count of committed instructions

## Operation
- The W register holds {valid, icode, stat, valE, valM, dstE, dstM}. The valid bit is internal.
- W register update at each edge, in priority order:
  - rst: load a bubble.
  - halted = 1: hold (freeze).
  - stall_W = 1: hold.
  - bubble_W = 1: load a bubble.
  - Otherwise: load the m_* inputs with valid = 1.
- A bubble is: valid = 0, icode = INOP, stat = SAOK, valE = 0, valM = 0, dstE = 15, dstM = 15.
- Register file writes happen at the edge, only when all of these hold: W valid, W_stat = SAOK, halted = 0.
  - If W_dstE ≠ 15: reg[W_dstE] ← W_valE.
  - If W_dstM ≠ 15: reg[W_dstM] ← W_valM.
  - If W_dstE = W_dstM ≠ 15, W_valM wins. This covers popq %rsp.
  - Writes happen on every such edge regardless of stall_W. While W is stalled, the same value is rewritten, which is harmless.
- Read ports are purely combinational and return contents as they were before the edge. There is no internal write-to-read bypass; decode forwards from the W_* outputs.
- halted is set at the edge that loads an input with m_stat ≠ SAOK, so it rises in the same cycle that W_stat shows the exception. It clears only on rst. The excepting instruction never writes the register file.
- retired increments at an edge when all of these hold: the current W is valid, W_stat = SAOK, and W is being replaced (not stalled, not frozen). It wraps modulo 2^64.
- Arithmetic: no width conversion; all data paths are 64 bits.

## Timing
- Latency from memory stage to W: 1 cycle. Latency from W to a register file commit: same edge as the next W update. A written value is visible on d_rval* in the cycle after that edge.
- Reset values:
  - W holds a bubble, so W_icode = 1, W_stat = 1, W_valE = 0, W_valM = 0, W_dstE = 15, W_dstM = 15.
  - Stat = 1, halted = 0, retired = 0.
  - All 15 registers = 0.
- rst asserted mid-operation overrides stall_W, bubble_W and halted. No write occurs on the reset edge.
- stall_W and bubble_W asserted together: stall wins.
- Read and write to the same register in one cycle: the read returns the old value.

## Test plan
- Reset, then read all IDs 0–15 → d_rvalA = 0 for every ID; Stat = 1; retired = 0.
- Load icode 3 (irmovq), valE = 0x1234, dstE = 2, stat 1; read srcA = 2 → 0x1234 two cycles after the input is applied; retired = 1 after the next load.
- Load popq with dstE = dstM = 4, valE = 0x100, valM = 0xABCD → reg[4] = 0xABCD.
- Load stat 3 with dstE = 5 → halted = 1 and Stat = 3 next cycle; reg[5] unchanged; W stays frozen; further inputs are ignored and retired stops counting.
- Hold stall_W = 1 for 3 cycles with bubble_W = 1 → W unchanged; retired does not increment while stalled; releasing both loads the next input.
- Assert rst while halted with nonzero registers → all outputs return to their reset values and all registers are zeroed.

Source files
------------

// File: rtl/writeback_regfile.sv
// ============================================================================
// Module   : writeback_regfile
// Purpose  : Y86-64 write-back stage. W pipeline register, 15-entry register
//            file with two combinational read ports, sticky halt, retire count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_regfile #(
  parameter int NREGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_W,
  input  logic        bubble_W,
  input  logic [3:0]  m_icode,
  input  logic [2:0]  m_stat,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [3:0]  W_icode,
  output logic [2:0]  W_stat,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [2:0]  Stat,
  output logic        halted,
  output logic [63:0] retired
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [3:0] INOP  = 4'd1;
  localparam logic [3:0] RNONE = 4'd15;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } wreg_t;

  localparam wreg_t W_BUBBLE = {1'b0, INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE};

  wreg_t       w_q, w_d;
  logic        halted_q, halted_d;
  logic [63:0] retired_q, retired_d;
  logic [63:0] regs_q [NREGS];
  logic        commit;

  // An excepting instruction (stat != SAOK) and anything after halt never commit.
  assign commit = w_q.valid && (w_q.stat == SAOK) && !halted_q;

  always_comb begin
    w_d       = w_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (!halted_q && !stall_W) begin
      if (bubble_W) begin
        w_d = W_BUBBLE;
      end else begin
        w_d = {1'b1, m_icode, m_stat, m_valE, m_valM, m_dstE, m_dstM};
        if (m_stat != SAOK) halted_d = 1'b1;
      end
    end
    if (commit && !stall_W) retired_d = retired_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= W_BUBBLE;
      halted_q  <= 1'b0;
      retired_q <= 64'd0;
    end else begin
      w_q       <= w_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // The valM write is placed last so it wins when dstE == dstM (popq %rsp).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 64'd0;
    end else if (commit) begin
      if (w_q.dstE != RNONE) regs_q[w_q.dstE] <= w_q.valE;
      if (w_q.dstM != RNONE) regs_q[w_q.dstM] <= w_q.valM;
    end
  end

  assign d_rvalA = (d_srcA == RNONE) ? 64'd0 : regs_q[d_srcA];
  assign d_rvalB = (d_srcB == RNONE) ? 64'd0 : regs_q[d_srcB];

  assign W_icode = w_q.icode;
  assign W_stat  = w_q.stat;
  assign W_valE  = w_q.valE;
  assign W_valM  = w_q.valM;
  assign W_dstE  = w_q.dstE;
  assign W_dstM  = w_q.dstM;
  assign Stat    = w_q.valid ? w_q.stat : SAOK;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Randomized self-checking bench for writeback_regfile against an
//            architectural reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst, stall_W, bubble_W;
  logic [3:0]  m_icode, m_dstE, m_dstM, d_srcA, d_srcB;
  logic [2:0]  m_stat;
  logic [63:0] m_valE, m_valM;
  logic [63:0] d_rvalA, d_rvalB, W_valE, W_valM, retired;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [2:0]  W_stat, Stat;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural view of the stage.
  logic [63:0] mreg [16];
  logic        mv, mhalt;
  logic [3:0]  mi, mdE, mdM;
  logic [2:0]  ms;
  logic [63:0] mE, mM, mret;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .stall_W(stall_W), .bubble_W(bubble_W),
    .m_icode(m_icode), .m_stat(m_stat), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .W_icode(W_icode), .W_stat(W_stat),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .Stat(Stat), .halted(halted), .retired(retired)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    m_icode = ic; m_stat = st; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
  endtask

  task automatic model_bubble();
    mv = 1'b0; mi = 4'd1; ms = 3'd1; mE = '0; mM = '0; mdE = 4'd15; mdM = 4'd15;
  endtask

  task automatic model_edge();
    logic do_commit;
    if (rst) begin
      for (int i = 0; i < 16; i++) mreg[i] = '0;
      model_bubble();
      mhalt = 1'b0;
      mret  = '0;
    end else begin
      do_commit = mv && (ms == 3'd1) && !mhalt;
      if (do_commit) begin
        if (mdE != 4'd15) mreg[mdE] = mE;
        if (mdM != 4'd15) mreg[mdM] = mM;
        if (!stall_W) mret = mret + 64'd1;
      end
      if (!mhalt && !stall_W) begin
        if (bubble_W) model_bubble();
        else begin
          mv = 1'b1; mi = m_icode; ms = m_stat; mE = m_valE; mM = m_valM;
          mdE = m_dstE; mdM = m_dstM;
          if (m_stat != 3'd1) mhalt = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("W_icode", 64'(W_icode), 64'(mi));
    check("W_stat",  64'(W_stat),  64'(ms));
    check("W_valE",  W_valE, mE);
    check("W_valM",  W_valM, mM);
    check("W_dstE",  64'(W_dstE), 64'(mdE));
    check("W_dstM",  64'(W_dstM), 64'(mdM));
    check("Stat",    64'(Stat), mv ? 64'(ms) : 64'd1);
    check("halted",  64'(halted), 64'(mhalt));
    check("retired", retired, mret);
    check("rvalA",   d_rvalA, mreg[d_srcA]);
    check("rvalB",   d_rvalB, mreg[d_srcB]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic read_all(input string tag);
    for (int id = 0; id < 16; id++) begin
      d_srcA = 4'(id);
      d_srcB = 4'(15 - id);
      #0.2;
      check(tag, d_rvalA, 64'd0);
      check(tag, d_rvalB, 64'd0);
    end
  endtask

  logic [63:0] ret_snap;

  initial begin
    rst = 1'b1; stall_W = 1'b0; bubble_W = 1'b0;
    d_srcA = 4'd0; d_srcB = 4'd0;
    set_in(4'd1, 3'd1, '0, '0, 4'd15, 4'd15);
    step();
    step();
    rst = 1'b0;
    check("rst_Stat", 64'(Stat), 64'd1);
    check("rst_retired", retired, 64'd0);
    read_all("rst_read");

    // irmovq $0x1234, %rdx
    set_in(4'd3, 3'd1, 64'h1234, '0, 4'd2, 4'd15);
    step();
    set_in(4'd1, 3'd1, '0, '0, 4'd15, 4'd15);
    d_srcA = 4'd2;
    step();
    check("irmovq_read", d_rvalA, 64'h1234);
    check("irmovq_retired", retired, 64'd1);

    // popq %rsp-like: dstE == dstM, valM must win
    set_in(4'hB, 3'd1, 64'h100, 64'hABCD, 4'd4, 4'd4);
    step();
    set_in(4'd1, 3'd1, '0, '0, 4'd15, 4'd15);
    d_srcA = 4'd4;
    step();
    check("popq_read", d_rvalA, 64'hABCD);

    // Stall with bubble also asserted: stall wins, retire count frozen
    set_in(4'd3, 3'd1, 64'h77, '0, 4'd6, 4'd15);
    step();
    ret_snap = retired;
    stall_W = 1'b1; bubble_W = 1'b1;
    set_in(4'd6, 3'd1, 64'h99, '0, 4'd7, 4'd15);
    repeat (3) begin
      step();
      check("stall_icode", 64'(W_icode), 64'd3);
      check("stall_retired", retired, ret_snap);
    end
    stall_W = 1'b0; bubble_W = 1'b0;
    step();
    check("release_icode", 64'(W_icode), 64'd6);

    // Address exception targeting %rbp: halts, never writes
    set_in(4'd5, 3'd3, 64'h55, 64'h66, 4'd5, 4'd15);
    d_srcA = 4'd5;
    step();
    check("exc_halted", 64'(halted), 64'd1);
    check("exc_Stat", 64'(Stat), 64'd3);
    ret_snap = retired;
    repeat (4) begin
      set_in(4'($urandom_range(0, 11)), 3'd1, {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
      check("frozen_reg5", d_rvalA, 64'd0);
      check("frozen_icode", 64'(W_icode), 64'd5);
      check("frozen_retired", retired, ret_snap);
    end

    // Reset while halted with nonzero registers
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_halted", 64'(halted), 64'd0);
    check("rst2_retired", retired, 64'd0);
    read_all("rst2_read");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 79) == 0);
      stall_W  = ($urandom_range(0, 7) == 0);
      bubble_W = ($urandom_range(0, 7) == 0);
      set_in(4'($urandom_range(0, 11)),
             ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
             {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      d_srcA = 4'($urandom_range(0, 15));
      d_srcB = 4'($urandom_range(0, 15));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
